qsn_deshift_controller_len3: RTL and testbench
==============================================

Name: qsn_deshift_controller_len3

Overview:
- Return-path (inverse) controller for the length-3 QSN barrel shifter.
- Records each forward shift factor when the forward controller issues it, and holds it in a small FIFO.
- When the matching message set returns from the check-node side, pops the oldest factor and drives registered left/right/merge selects for the inverse cyclic shift (3 − s) mod 3, restoring variable-node order.
- Sits beside the forward QSN controller in the partial message-passing datapath.

Parameters:
- FIFO_DEPTH, 4, number of outstanding shift factors; power of two, ≥2.
- PERMUTATION_LENGTH, 3, cyclic length; fixed at 3 and checked at elaboration.

Ports:
- sys_clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fwd_shift_valid  input  1  forward factor issued this cycle.
- fwd_shift_factor  input  2  forward shift factor s (0..2 legal).
- fwd_shift_ready  output  1  FIFO can accept a factor (not full).
- ret_msg_valid  input  1  returning message set present; request pop.
- left_sel  output  2  inverse-shift left-stage select.
- right_sel  output  2  inverse-shift right-stage select.
- merge_sel  output  2  inverse-shift merge select.
- sel_valid  output  1  selects valid this cycle.
- occupancy  output  $clog2(FIFO_DEPTH)+1  stored factor count.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; pointers and occupancy = 0.
  - left_sel, right_sel, merge_sel = 0; sel_valid = 0; fwd_shift_ready = 1.
- Push accepted iff fwd_shift_valid && fwd_shift_ready; fwd_shift_ready = (occupancy != FIFO_DEPTH).
- Push is refused when full, even if a pop occurs in the same cycle. The factor is lost; the producer must hold it.
- Pop occurs iff ret_msg_valid && occupancy != 0.
- Pop on empty: nothing popped; sel_valid = 0 next cycle. There is no same-cycle push bypass; a push while empty is visible for popping next cycle.
- Simultaneous accepted push and pop (not full, not empty): occupancy is unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Latency is 1 cycle: a pop in cycle N yields registered selects and sel_valid = 1 in cycle N+1. Outputs hold their last value when sel_valid = 0.
- Inverse mapping, with t = (3 − s) mod 3 and selects derived from t exactly as the forward controller derives them from its factor:
  - s=0 → t=0: left=0, right=0, merge=00.
  - s=1 → t=2: left=2, right=1, merge=01.
  - s=2 → t=1: left=1, right=2, merge=11.
  - s=3 (illegal): treated as s=0, so all selects = 0.
- Mid-operation reset clears all stored factors immediately; in-flight selects are discarded.

Optional Feature:
- Macro: QSN_DESHIFT_ERR_CHK_EN.
- With the macro defined, three extra sticky outputs are added, each 1-bit and cleared only by rst:
  - err_overflow: set by a push attempt while full.
  - err_underflow: set by ret_msg_valid while empty.
  - err_illegal_shift: set when an accepted push has factor 3.
- Without the macro, these ports and their logic are absent. The datapath behaviour is identical in both builds.

Decomposition:
- Shared package qsn_pkg holds:
  - QSN_LEN3 = 3 and the shift-factor width.
  - The forward select function, reused here on t.
  - The inverse-factor function (3 − s) mod 3.
- One natural sub-module: qsn_shift_fifo, the parameterised FIFO of 2-bit factors with occupancy. The controller wraps it with the select-generation register stage.

Test Plan:
- Reset then push s=1,2,0 on consecutive cycles, then assert ret_msg_valid for 3 cycles → selects in order (2,1,01), (1,2,11), (0,0,00); sel_valid high for those 3 cycles; occupancy ends at 0.
- Fill to 4 with no pops → fwd_shift_ready = 0, occupancy = 4.
  - Push s=2 while full → occupancy stays 4; the push is dropped.
  - With the macro, err_overflow = 1.
- With occupancy = 2, push and pop in the same cycle → occupancy stays 2; the popped value is the oldest factor.
- Empty FIFO: assert ret_msg_valid and push s=1 in the same cycle → next cycle sel_valid = 0, occupancy = 1; a pop the following cycle gives left=2.
- Push s=3 (illegal) then pop → all selects 0 with sel_valid = 1; with the macro, err_illegal_shift = 1.
- Assert rst mid-stream with occupancy = 3 and sel_valid = 1 → all outputs 0 and occupancy 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qsn_deshift_controller_len3_pkg.sv
// Purpose: shared types and select functions for the length-3 QSN shifter and its inverse controller.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
// Contents: QSN_LEN3, SHIFT_W, shift_t, sel_t, fwd_sel() (factor -> selects), inv_shift() ((3 - s) mod 3).
package qsn_pkg;

  localparam int QSN_LEN3 = 3;
  localparam int SHIFT_W  = 2;

  typedef logic [SHIFT_W-1:0] shift_t;

  // Select bundle for one shifter setting, packed as {left, right, merge}.
  typedef struct packed {
    logic [1:0] lsel;
    logic [1:0] rsel;
    logic [1:0] msel;
  } sel_t;

  // Forward select mapping. Factor 3 is not a legal rotation and selects
  // the identity setting.
  function automatic sel_t fwd_sel(input shift_t t);
    sel_t s;
    s = '0;
    case (t)
      2'd1: begin s.lsel = 2'd1; s.rsel = 2'd2; s.msel = 2'b11; end
      2'd2: begin s.lsel = 2'd2; s.rsel = 2'd1; s.msel = 2'b01; end
      default: s = '0;
    endcase
    return s;
  endfunction

  // Inverse rotation amount (3 - s) mod 3. Illegal s=3 collapses to 0.
  function automatic shift_t inv_shift(input shift_t s);
    shift_t t;
    case (s)
      2'd1:    t = 2'd2;
      2'd2:    t = 2'd1;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/qsn_deshift_controller_len3_if.sv
// Purpose: bundle of forward-factor, return-request and select signals for the deshift controller.
// Latency: none (wiring only).
// Backpressure: fwd_shift_ready low means the producer must hold its factor.
// Modports: slave = controller side, master = producer/consumer side.
// Optional: QSN_DESHIFT_ERR_CHK_EN adds sticky err_overflow / err_underflow / err_illegal_shift.
interface qsn_deshift_controller_len3_if
  import qsn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) ();

  logic                        fwd_shift_valid;
  shift_t                      fwd_shift_factor;
  logic                        fwd_shift_ready;
  logic                        ret_msg_valid;
  logic [1:0]                  left_sel;
  logic [1:0]                  right_sel;
  logic [1:0]                  merge_sel;
  logic                        sel_valid;
  logic [$clog2(FIFO_DEPTH):0] occupancy;
`ifdef QSN_DESHIFT_ERR_CHK_EN
  logic                        err_overflow;
  logic                        err_underflow;
  logic                        err_illegal_shift;

  modport slave (
    input  fwd_shift_valid, fwd_shift_factor, ret_msg_valid,
    output fwd_shift_ready, left_sel, right_sel, merge_sel, sel_valid, occupancy,
    output err_overflow, err_underflow, err_illegal_shift
  );
  modport master (
    output fwd_shift_valid, fwd_shift_factor, ret_msg_valid,
    input  fwd_shift_ready, left_sel, right_sel, merge_sel, sel_valid, occupancy,
    input  err_overflow, err_underflow, err_illegal_shift
  );
`else
  modport slave (
    input  fwd_shift_valid, fwd_shift_factor, ret_msg_valid,
    output fwd_shift_ready, left_sel, right_sel, merge_sel, sel_valid, occupancy
  );
  modport master (
    output fwd_shift_valid, fwd_shift_factor, ret_msg_valid,
    input  fwd_shift_ready, left_sel, right_sel, merge_sel, sel_valid, occupancy
  );
`endif

endinterface

// File: rtl/qsn_shift_fifo.sv
// Purpose: FIFO of 2-bit shift factors with occupancy count, pointers wrapping modulo DEPTH.
// Latency: a pushed factor is poppable the cycle after the push; pop data is read combinationally.
// Backpressure: push_rdy low when full; a push while full is dropped even if a pop happens that cycle.
// Ports: sys_clk, rst (async high), push_vld/push_dat/push_rdy, pop_req/pop_vld/pop_dat, occupancy.
module qsn_shift_fifo
  import qsn_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        push_vld,
  input  shift_t      push_dat,
  output logic        push_rdy,
  input  logic        pop_req,
  output logic        pop_vld,
  output shift_t      pop_dat,
  output logic [AW:0] occupancy
);

  shift_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_acc;

  // Readiness is judged on the registered count only, so a same-cycle pop
  // never frees a slot for the push.
  assign push_rdy = (occupancy != (AW+1)'(DEPTH));
  assign push_acc = push_vld && push_rdy;
  assign pop_vld  = pop_req && (occupancy != '0);
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_vld) rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop_vld})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/qsn_deshift_controller_len3.sv
// Purpose: inverse-shift controller; queues forward factors and drives selects for (3 - s) mod 3 on return.
// Latency: 1 cycle from an accepted pop to registered selects with sel_valid high; selects hold otherwise.
// Backpressure: fwd_shift_ready deasserts when FIFO_DEPTH factors are outstanding.
// Ports: sys_clk, rst (async high), bus (slave modport: forward factor in, return request in, selects/occupancy out).
// Optional: define QSN_DESHIFT_ERR_CHK_EN for sticky overflow/underflow/illegal-factor flags.
module qsn_deshift_controller_len3
  import qsn_pkg::*;
#(
  parameter int FIFO_DEPTH         = 4,
  parameter int PERMUTATION_LENGTH = 3
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  qsn_deshift_controller_len3_if.slave  bus
);

  if (PERMUTATION_LENGTH != QSN_LEN3) begin : g_bad_len
    $error("qsn_deshift_controller_len3: PERMUTATION_LENGTH must be 3");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("qsn_deshift_controller_len3: FIFO_DEPTH must be a power of two >= 2");
  end

  logic   pop_vld;
  shift_t pop_dat;
  sel_t   sel_q;
  logic   sel_vld_q;

  qsn_shift_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .push_vld  (bus.fwd_shift_valid),
    .push_dat  (bus.fwd_shift_factor),
    .push_rdy  (bus.fwd_shift_ready),
    .pop_req   (bus.ret_msg_valid),
    .pop_vld   (pop_vld),
    .pop_dat   (pop_dat),
    .occupancy (bus.occupancy)
  );

  // Undo the forward rotation by applying the forward select map to the
  // complementary factor.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
    end else begin
      sel_vld_q <= pop_vld;
      if (pop_vld) sel_q <= fwd_sel(inv_shift(pop_dat));
    end
  end

  assign bus.left_sel  = sel_q.lsel;
  assign bus.right_sel = sel_q.rsel;
  assign bus.merge_sel = sel_q.msel;
  assign bus.sel_valid = sel_vld_q;

`ifdef QSN_DESHIFT_ERR_CHK_EN
  logic err_ovf_q;
  logic err_udf_q;
  logic err_ill_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
      err_ill_q <= 1'b0;
    end else begin
      if (bus.fwd_shift_valid && !bus.fwd_shift_ready) err_ovf_q <= 1'b1;
      if (bus.ret_msg_valid && (bus.occupancy == '0)) err_udf_q <= 1'b1;
      if (bus.fwd_shift_valid && bus.fwd_shift_ready && (bus.fwd_shift_factor == 2'd3))
        err_ill_q <= 1'b1;
    end
  end

  assign bus.err_overflow      = err_ovf_q;
  assign bus.err_underflow     = err_udf_q;
  assign bus.err_illegal_shift = err_ill_q;
`endif

endmodule

// File: tb/tb_qsn_deshift_controller_len3.sv
// Purpose: directed scoreboard bench for qsn_deshift_controller_len3 (selects, occupancy, full/empty, reset).
// Latency: expected selects are queued when a pop is issued and checked when sel_valid appears.
// Backpressure: full-FIFO pushes are issued deliberately to confirm they are dropped.
module tb_qsn_deshift_controller_len3;
  import qsn_pkg::*;

  logic sys_clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [5:0] exp_q[$];

  qsn_deshift_controller_len3_if #(.FIFO_DEPTH(4)) bus ();

  qsn_deshift_controller_len3 #(.FIFO_DEPTH(4), .PERMUTATION_LENGTH(3)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected {left, right, merge} for the next valid select cycle.
  task automatic exp_push(input logic [1:0] l, input logic [1:0] r, input logic [1:0] m);
    exp_q.push_back({l, r, m});
  endtask

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic pv, input logic [1:0] pf, input logic rv);
    bus.fwd_shift_valid  = pv;
    bus.fwd_shift_factor = pf;
    bus.ret_msg_valid    = rv;
    @(posedge sys_clk);
    #1;
    bus.fwd_shift_valid  = 1'b0;
    bus.fwd_shift_factor = 2'd0;
    bus.ret_msg_valid    = 1'b0;
  endtask

  // Monitor: every valid select cycle must match the oldest expectation.
  always @(negedge sys_clk) begin
    if (!rst && bus.sel_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sel_valid", 1, 0);
      end else begin
        chk("sel_triple", int'({bus.left_sel, bus.right_sel, bus.merge_sel}), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.fwd_shift_valid  = 1'b0;
    bus.fwd_shift_factor = 2'd0;
    bus.ret_msg_valid    = 1'b0;
    #2;
    chk("rst_occ", int'(bus.occupancy), 0);
    chk("rst_ready", int'(bus.fwd_shift_ready), 1);
    chk("rst_sel_valid", int'(bus.sel_valid), 0);
    chk("rst_sels", int'({bus.left_sel, bus.right_sel, bus.merge_sel}), 0);
    repeat (2) @(posedge sys_clk);
    #1 rst = 1'b0;

    // In-order inverse selects for s = 1, 2, 0.
    cyc(1, 2'd1, 0); cyc(1, 2'd2, 0); cyc(1, 2'd0, 0);
    chk("occ_after_3_push", int'(bus.occupancy), 3);
    exp_push(2'd2, 2'd1, 2'b01); cyc(0, 0, 1);
    exp_push(2'd1, 2'd2, 2'b11); cyc(0, 0, 1);
    exp_push(2'd0, 2'd0, 2'b00); cyc(0, 0, 1);
    chk("occ_drained", int'(bus.occupancy), 0);
    cyc(0, 0, 0);
    chk("sel_valid_idle", int'(bus.sel_valid), 0);

    // Fill to full; pushes while full are dropped, even alongside a pop.
    cyc(1, 2'd2, 0); cyc(1, 2'd1, 0); cyc(1, 2'd2, 0); cyc(1, 2'd1, 0);
    chk("occ_full", int'(bus.occupancy), 4);
    chk("ready_full", int'(bus.fwd_shift_ready), 0);
    cyc(1, 2'd2, 0);
    chk("occ_full_drop", int'(bus.occupancy), 4);
`ifdef QSN_DESHIFT_ERR_CHK_EN
    chk("err_overflow", int'(bus.err_overflow), 1);
`endif
    exp_push(2'd1, 2'd2, 2'b11); cyc(1, 2'd0, 1);
    chk("occ_full_pushpop", int'(bus.occupancy), 3);
    exp_push(2'd2, 2'd1, 2'b01); cyc(0, 0, 1);
    chk("occ_two", int'(bus.occupancy), 2);
    // Simultaneous push/pop at occupancy 2: oldest factor (2) comes out.
    exp_push(2'd1, 2'd2, 2'b11); cyc(1, 2'd0, 1);
    chk("occ_pushpop_2", int'(bus.occupancy), 2);
    exp_push(2'd2, 2'd1, 2'b01); cyc(0, 0, 1);
    exp_push(2'd0, 2'd0, 2'b00); cyc(0, 0, 1);
    chk("occ_drained_2", int'(bus.occupancy), 0);

    // Pop on empty with a same-cycle push: no bypass.
    cyc(1, 2'd1, 1);
    chk("empty_pop_sel_valid", int'(bus.sel_valid), 0);
    chk("empty_pop_occ", int'(bus.occupancy), 1);
`ifdef QSN_DESHIFT_ERR_CHK_EN
    chk("err_underflow", int'(bus.err_underflow), 1);
`endif
    exp_push(2'd2, 2'd1, 2'b01); cyc(0, 0, 1);
    chk("after_empty_left", int'(bus.left_sel), 2);

    // Illegal factor 3 maps to identity selects.
    cyc(1, 2'd3, 0);
`ifdef QSN_DESHIFT_ERR_CHK_EN
    chk("err_illegal_shift", int'(bus.err_illegal_shift), 1);
`endif
    exp_push(2'd0, 2'd0, 2'b00); cyc(0, 0, 1);
    chk("illegal_sel_valid", int'(bus.sel_valid), 1);

    // Asynchronous reset mid-stream with occupancy 3 and live selects.
    cyc(1, 2'd1, 0); cyc(1, 2'd2, 0); cyc(1, 2'd0, 0); cyc(1, 2'd1, 0);
    exp_push(2'd2, 2'd1, 2'b01); cyc(0, 0, 1);
    @(negedge sys_clk); #1;
    chk("pre_rst_sel_valid", int'(bus.sel_valid), 1);
    chk("pre_rst_occ", int'(bus.occupancy), 3);
    rst = 1'b1;
    #1;
    chk("async_rst_occ", int'(bus.occupancy), 0);
    chk("async_rst_sel_valid", int'(bus.sel_valid), 0);
    chk("async_rst_sels", int'({bus.left_sel, bus.right_sel, bus.merge_sel}), 0);
    chk("async_rst_ready", int'(bus.fwd_shift_ready), 1);
`ifdef QSN_DESHIFT_ERR_CHK_EN
    chk("async_rst_err", int'({bus.err_overflow, bus.err_underflow, bus.err_illegal_shift}), 0);
`endif
    @(posedge sys_clk); #1 rst = 1'b0;
    cyc(0, 0, 1);
    chk("post_rst_pop_empty", int'(bus.sel_valid), 0);
    chk("post_rst_occ", int'(bus.occupancy), 0);

    repeat (2) @(posedge sys_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
